fetch_sequencer: RTL

Multicycle instruction-fetch sequencer that owns the program counter. It issues word reads to instruction memory over a request/grant/response handshake and hands each fetched instruction, with its PC and PC+4, to decode. It is the consumer of the branch-target adder output: it accepts taken-branch and jump redirects, discards any fetch already in flight, and restarts fetching at the new target.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/pc_next_select.sv | 31 +++
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch sequencer.
//   fetch_state_t     - sequencer FSM states
//   INSTR_BYTES       - size of one instruction word in bytes
//   DEFAULT_RESET_PC  - default program counter after reset
//   is_word_aligned() - true when the two low address bits are zero
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_select.sv
// pc_next_select: combinational redirect arbitration for the fetch sequencer.
// Ports:
//   pc                 in  32  current program counter
//   branch_taken       in  1   branch redirect strobe
//   branch_target      in  32  branch target address
//   jump_taken         in  1   jump redirect strobe
//   jump_target        in  32  jump target address
//   redirect           out 1   any redirect requested this cycle
//   redirect_target    out 32  selected target (jump has priority)
//   target_misaligned  out 1   redirect requested to a non-word-aligned target
//   pc_plus4           out 32  pc + 4, wrapping at 2^32
module pc_next_select
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] redirect_target,
  output logic        target_misaligned,
  output logic [31:0] pc_plus4
);

  assign redirect          = branch_taken | jump_taken;
  assign redirect_target   = jump_taken ? jump_target : branch_target;
  assign target_misaligned = redirect & ~is_word_aligned(redirect_target[1:0]);
  assign pc_plus4          = pc + 32'(INSTR_BYTES);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle instruction-fetch sequencer owning the PC.
// Issues one word read at a time over a req/gnt/rsp handshake, buffers the
// returned instruction for decode, and restarts at branch/jump targets,
// discarding any fetch already in flight.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and byte address (registered)
//   imem_gnt            memory accepted the request this cycle
//   imem_rsp_valid/data instruction response
//   instr_valid, instr, instr_pc, instr_pc_plus4  buffered instruction to decode
//   instr_ready         decode consumes the instruction this cycle
//   branch_taken/target, jump_taken/target        redirect strobes and targets
//   misalign_fault      sticky: a redirect target was not word-aligned
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic        misalign_fault
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         discard_reg, discard_next;
  logic         fault_next;
  logic         capture;

  logic         redirect;
  logic [31:0]  redirect_target;
  logic         target_misaligned;
  logic [31:0]  pc_plus4;

  pc_next_select u_pc_next_select (
    .pc                (pc_reg),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump_taken        (jump_taken),
    .jump_target       (jump_target),
    .redirect          (redirect),
    .redirect_target   (redirect_target),
    .target_misaligned (target_misaligned),
    .pc_plus4          (pc_plus4)
  );

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    discard_next = discard_reg;
    fault_next   = misalign_fault;
    capture      = 1'b0;

    case (state_reg)
      IDLE:  state_next = FETCH;
      FETCH: if (imem_gnt) state_next = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          if (discard_reg) begin
            discard_next = 1'b0;
            state_next   = FETCH;
          end else begin
            capture    = 1'b1;
            pc_next    = pc_plus4;
            state_next = HOLD;
          end
        end
      end
      HOLD:    if (instr_ready) state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase

    // A redirect overrides the normal flow; nothing is captured in its cycle.
    if (redirect && (state_reg != IDLE) && (state_reg != HALT)) begin
      capture = 1'b0;
      if (target_misaligned) begin
        fault_next   = 1'b1;
        pc_next      = pc_reg;
        discard_next = 1'b0;
        state_next   = HALT;
      end else begin
        pc_next = redirect_target;
        case (state_reg)
          FETCH: begin
            // A request granted this cycle still belongs to the old stream.
            if (imem_gnt) begin
              discard_next = 1'b1;
              state_next   = WAIT;
            end else begin
              state_next = FETCH;
            end
          end
          WAIT: begin
            // A response arriving now closes the old request outright.
            if (imem_rsp_valid) begin
              discard_next = 1'b0;
              state_next   = FETCH;
            end else begin
              discard_next = 1'b1;
              state_next   = WAIT;
            end
          end
          HOLD:    state_next = FETCH;
          default: state_next = state_reg;
        endcase
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      discard_reg    <= 1'b0;
      misalign_fault <= 1'b0;
      imem_req       <= 1'b0;
      imem_addr      <= RESET_PC;
      instr_valid    <= 1'b0;
      instr          <= 32'h0;
      instr_pc       <= 32'h0;
      instr_pc_plus4 <= 32'h0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      discard_reg    <= discard_next;
      misalign_fault <= fault_next;
      imem_req       <= (state_next == FETCH);
      imem_addr      <= pc_next;
      instr_valid    <= (state_next == HOLD);
      if (capture) begin
        instr          <= imem_rsp_data;
        instr_pc       <= pc_reg;
        instr_pc_plus4 <= pc_plus4;
      end
    end
  end

endmodule
